keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  4x4 matrix keypad scanner/debouncer fed by the 1 kHz tick from freq_divider.pulse_out.
//  Drives columns one at a time, samples rows, debounces, emits one-cycle key event + code.
//  Sits between freq_divider and the key-consuming control logic (display/ALU FSM).
// PARAMETERS
//  DEBOUNCE_TICKS  20   consecutive ticks a key must be stable pressed/released (>=2)
//  REPEAT_TICKS    250  ticks between auto-repeat events (used only with KEYPAD_REPEAT_EN)
// PORTS
//  clk        in   1  system clock (27 MHz)
//  n_reset    in   1  synchronous, active-low reset
//  tick_i     in   1  1-clk strobe from freq_divider (1 kHz)
//  row_i      in   4  keypad rows, active-low, pulled up, asynchronous to clk
//  col_o      out  4  keypad columns, one-hot active-low drive
//  key_valid  out  1  1-clk pulse: new debounced key event
//  key_code   out  4  row_idx*4 + col_idx; held until next event
// BEHAVIOUR
//  - Single clock, synchronous active-low reset n_reset; all state sampled on posedge clk.
//  - row_i passes through 2-FF synchronizer; FSM sees row_s (2-clk latency). Reset value 4'hF.
//  - Reset: state=SCAN, col_idx=0, col_o=4'b1110, key_valid=0, key_code=0, counters=0.
//  - FSM advances only on clk cycles with tick_i=1, except key_valid clear (every clk).
//  - SCAN: on tick, if row_s!=4'hF -> latch row_idx = lowest-index low row, cnt=1, go DEBOUNCE;
//    else col_idx=(col_idx+1)%4 (wraps 3->0), col_o=~(4'b1<<col_idx).
//  - DEBOUNCE: column held. On tick: latched row still low -> cnt++; when cnt reaches
//    DEBOUNCE_TICKS -> key_valid=1 next clk, key_code={row_idx,col_idx}, go HOLD, cnt=0.
//    Latched row high on tick -> go SCAN, same column, no event (bounce rejected).
//  - HOLD: column held. On tick: latched row high -> cnt++, low -> cnt=0 (release bounce);
//    cnt reaches DEBOUNCE_TICKS -> go SCAN, advance column. Other keys ignored while in HOLD.
//  - Multiple rows low at same column: lowest row index wins; other columns unseen until release.
//  - key_valid high exactly 1 clk per event; never two events in consecutive clks.
//  - tick_i high for several clks: each high clk counts as one tick (no edge detect).
//  - Reset mid-operation: immediate return to reset values next clk, pending event discarded.
//  - Counter width $clog2(max(DEBOUNCE_TICKS,REPEAT_TICKS)+1); no overflow (saturates at limit).
// CONFIGURATION
//  `KEYPAD_REPEAT_EN defined: in HOLD, a second counter rep_cnt counts ticks while pressed;
//   at REPEAT_TICKS -> key_valid pulse with same key_code, rep_cnt=0; cleared on release
//   bounce/exit. First repeat REPEAT_TICKS ticks after initial event.
//  Not defined: exactly one event per press; rep_cnt and REPEAT_TICKS logic absent.
// STRUCTURE
//  keypad_pkg: typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} kp_state_t;
//   localparams NUM_ROWS=4, NUM_COLS=4, COL_RESET=4'b1110; key_code constants (KEY_0..KEY_F).
//  Sub-module: sync_2ff (parameterised width, reset value) for row_i synchronizer.
//  FSM, column rotator and counters inline in keypad_scanner.
// TESTING
//  Bench: 27 MHz clk, tick_i every 27_000 clk (or 1-in-10 clk for speed), DEBOUNCE_TICKS=20.
//  1 Reset: n_reset=0 5 clks -> col_o=4'b1110, key_valid=0, key_code=0; cols rotate 1110,1101,
//    1011,0111,1110 on successive idle ticks.
//  2 Press row1/col1 (row_i[1]=0 when col_o[1]=0) 30 ticks -> exactly one key_valid, key_code=5.
//  3 Bounce: press 10 ticks, release 3, press 10 -> no key_valid; steady 20 more -> one event.
//  4 Hold row3/col2 1000 ticks, no macro -> single event code 14; with KEYPAD_REPEAT_EN,
//    REPEAT_TICKS=250 -> events at 20, 270, 520, 770 ticks (4 total), all code 14.
//  5 Rows 0 and 2 low on col3 -> key_code=3; after release next event requires fresh press.
//  6 n_reset=0 at debounce tick 15 -> no event, col_o=4'b1110; release re-press -> normal event.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// FSM state encodings, matrix geometry, key codes and small decode helpers.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} kp_state_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;
    localparam logic [NUM_ROWS-1:0] ROWS_IDLE = 4'hF;

    // Flat state encodings used by the scanner's state register.
    localparam logic [1:0] ST_SCAN     = SCAN;
    localparam logic [1:0] ST_DEBOUNCE = DEBOUNCE;
    localparam logic [1:0] ST_HOLD     = HOLD;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    // Rows are active-low; the lowest-numbered low row wins.
    function automatic logic [1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!rows[r]) idx = 2'(r);
        end
        return idx;
    endfunction

    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with configurable width and reset value.
module sync_2ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: both stages reset to the idle level so no phantom input appears after reset.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner/debouncer advanced by a 1 kHz tick; one-clk key event + code.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_TICKS   = 250
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       tick_i,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int CNT_MAX = (DEBOUNCE_TICKS > REPEAT_TICKS) ? DEBOUNCE_TICKS : REPEAT_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_TICKS - 1);
`endif

    logic [3:0]       row_s;
    logic [1:0]       state;
    logic [1:0]       col_idx;
    logic [1:0]       next_col;
    logic [1:0]       row_idx;
    logic [CNT_W-1:0] cnt;
    logic             key_low;
`ifdef KEYPAD_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt;
`endif

    sync_2ff #(
        .WIDTH       (NUM_ROWS),
        .RESET_VALUE (ROWS_IDLE)
    ) u_row_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .d       (row_i),
        .q       (row_s)
    );

    assign next_col = col_idx + 2'd1;
    assign key_low  = ~row_s[row_idx];

    // cnt is compared against the last value before the limit, so it never
    // grows past DEBOUNCE_TICKS-1 and cannot wrap.
    // NOTE: all state uses non-blocking assignments so every branch sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state     <= ST_SCAN;
            col_idx   <= 2'd0;
            col_o     <= COL_RESET;
            row_idx   <= 2'd0;
            cnt       <= '0;
            key_valid <= 1'b0;
            key_code  <= KEY_0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (tick_i) begin
                case (state)
                    ST_SCAN: begin
                        if (row_s != ROWS_IDLE) begin
                            row_idx <= lowest_low_row(row_s);
                            cnt     <= CNT_W'(1);
                            state   <= ST_DEBOUNCE;
                        end else begin
                            col_idx <= next_col;
                            col_o   <= col_drive(next_col);
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (key_low) begin
                            if (cnt == DEB_LAST) begin
                                key_valid <= 1'b1;
                                key_code  <= {row_idx, col_idx};
                                cnt       <= '0;
                                state     <= ST_HOLD;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt   <= '0;
`endif
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else begin
                            // Bounce: rescan the same column without emitting.
                            cnt   <= '0;
                            state <= ST_SCAN;
                        end
                    end
                    ST_HOLD: begin
                        if (key_low) begin
                            cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                            if (rep_cnt == REP_LAST) begin
                                key_valid <= 1'b1;
                                rep_cnt   <= '0;
                            end else begin
                                rep_cnt <= rep_cnt + CNT_W'(1);
                            end
`endif
                        end else begin
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt <= '0;
`endif
                            if (cnt == DEB_LAST) begin
                                cnt     <= '0;
                                state   <= ST_SCAN;
                                col_idx <= next_col;
                                col_o   <= col_drive(next_col);
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= ST_SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model, tick-level reference model,
// per-cycle output compare and directed press/bounce/hold/reset scenarios.
module tb_keypad_scanner;

    localparam int DEB         = 20;
    localparam int REP         = 250;
    localparam int TICK_PERIOD = 10;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       tick_i = 1'b0;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic       key_valid;
    logic [3:0] key_code;

    keypad_scanner #(
        .DEBOUNCE_TICKS (DEB),
        .REPEAT_TICKS   (REP)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .tick_i    (tick_i),
        .row_i     (row_i),
        .col_o     (col_o),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Physical keypad: a pressed key shorts its row to its column.
    bit pressed [4][4];

    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && col_o[c] === 1'b0) row_i[r] = 1'b0;
    end

    // Tick source: one clk in TICK_PERIOD, plus optional forced back-to-back ticks.
    int unsigned cyc = 0;
    int          force_cnt = 0;
    always @(negedge clk) begin
        cyc++;
        if (force_cnt > 0) begin
            tick_i = 1'b1;
            force_cnt--;
        end else begin
            tick_i = (cyc % TICK_PERIOD == 0);
        end
    end

    // Reference model at tick granularity: which column is scanned, how long the
    // candidate key has been seen pressed / released, and the events this produces.
    int       m_col, m_mode, m_row, m_run, m_rep;   // m_mode: 0 looking, 1 confirming, 2 held
    int       tick_num = 0;
    bit       exp_valid = 1'b0;
    logic [3:0] exp_code = 4'h0;
    bit       model_live = 1'b0;

    task automatic model_step();
        int hit;
        exp_valid = 1'b0;
        if (!n_reset) begin
            m_col = 0; m_mode = 0; m_row = 0; m_run = 0; m_rep = 0;
            exp_code = 4'h0;
            model_live = 1'b1;
            return;
        end
        if (!tick_i) return;
        tick_num++;
        case (m_mode)
            0: begin
                hit = -1;
                for (int r = 3; r >= 0; r--) if (pressed[r][m_col]) hit = r;
                if (hit >= 0) begin
                    m_row = hit; m_run = 1; m_mode = 1;
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end
            1: begin
                if (pressed[m_row][m_col]) begin
                    m_run++;
                    if (m_run == DEB) begin
                        exp_valid = 1'b1;
                        exp_code  = 4'(m_row * 4 + m_col);
                        m_mode = 2; m_run = 0; m_rep = 0;
                    end
                end else begin
                    m_mode = 0; m_run = 0;
                end
            end
            default: begin
                if (pressed[m_row][m_col]) begin
                    m_run = 0;
`ifdef KEYPAD_REPEAT_EN
                    m_rep++;
                    if (m_rep == REP) begin
                        exp_valid = 1'b1;
                        m_rep = 0;
                    end
`endif
                end else begin
                    m_rep = 0;
                    m_run++;
                    if (m_run == DEB) begin
                        m_mode = 0; m_run = 0;
                        m_col = (m_col + 1) % 4;
                    end
                end
            end
        endcase
    endtask

    always @(posedge clk) model_step();

    // Per-cycle compare plus event bookkeeping for the directed checks.
    int         ev_count = 0;
    logic [3:0] ev_code = 4'h0;
    int         ev_ticks[$];

    always @(negedge clk) begin
        if (model_live) begin
            check("col_o", 32'(col_o), 32'(4'b1111 ^ (4'b0001 << m_col)));
            check("key_valid", 32'(key_valid), 32'(exp_valid));
            check("key_code", 32'(key_code), 32'(exp_code));
        end
        if (key_valid === 1'b1) begin
            ev_count++;
            ev_code = key_code;
            ev_ticks.push_back(tick_num);
        end
    end

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!tick_i && n < 4 * TICK_PERIOD);
        if (!tick_i) check("tick_timeout", 32'(n), 32'(0));
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pressed[r][c] = 1'b0;
    endtask

    logic [3:0] rot_exp [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    int         ev0;
    int         budget;

    initial begin
        release_all();

        // Reset state and idle column rotation.
        repeat (5) @(negedge clk);
        #1;
        check("reset_col", 32'(col_o), 32'(4'b1110));
        check("reset_valid", 32'(key_valid), 32'(0));
        check("reset_code", 32'(key_code), 32'(0));
        n_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            check("rotate_col", 32'(col_o), 32'(rot_exp[i]));
        end

        // Three back-to-back tick clks advance three columns.
        force_cnt = 3;
        repeat (6) @(negedge clk);
        #1;
        check("stretch_col", 32'(col_o), 32'(4'b0111));
        wait_tick();
        check("stretch_wrap", 32'(col_o), 32'(4'b1110));

        // Single press row1/col1.
        ev0 = ev_count;
        pressed[1][1] = 1'b1;
        wait_ticks(30);
        check("press_events", 32'(ev_count - ev0), 32'(1));
        check("press_code", 32'(ev_code), 32'(5));
        release_all();
        wait_ticks(25);

        // Bounce rejection on row2/col0.
        ev0 = ev_count;
        pressed[2][0] = 1'b1;
        wait_ticks(10);
        pressed[2][0] = 1'b0;
        wait_ticks(3);
        pressed[2][0] = 1'b1;
        wait_ticks(10);
        check("bounce_no_event", 32'(ev_count - ev0), 32'(0));
        wait_ticks(20);
        check("bounce_then_event", 32'(ev_count - ev0), 32'(1));
        check("bounce_code", 32'(ev_code), 32'(8));
        release_all();
        wait_ticks(25);

        // Long hold row3/col2.
        ev0 = ev_count;
        pressed[3][2] = 1'b1;
        wait_ticks(1000);
`ifdef KEYPAD_REPEAT_EN
        check("hold_events", 32'(ev_count - ev0), 32'(4));
        if (ev_count - ev0 >= 2)
            check("repeat_spacing", 32'(ev_ticks[ev0 + 1] - ev_ticks[ev0]), 32'(REP));
`else
        check("hold_events", 32'(ev_count - ev0), 32'(1));
`endif
        check("hold_code", 32'(ev_code), 32'(14));
        release_all();
        wait_ticks(25);

        // Rows 0 and 2 together on col3: lowest row wins.
        ev0 = ev_count;
        pressed[0][3] = 1'b1;
        pressed[2][3] = 1'b1;
        wait_ticks(30);
        check("multi_events", 32'(ev_count - ev0), 32'(1));
        check("multi_code", 32'(ev_code), 32'(3));
        release_all();
        wait_ticks(25);
        check("multi_release_quiet", 32'(ev_count - ev0), 32'(1));
        pressed[2][3] = 1'b1;
        wait_ticks(30);
        check("fresh_press_events", 32'(ev_count - ev0), 32'(2));
        check("fresh_press_code", 32'(ev_code), 32'(11));
        release_all();
        wait_ticks(25);

        // Reset in the middle of debouncing.
        ev0 = ev_count;
        pressed[1][1] = 1'b1;
        budget = 0;
        while (!(m_mode == 1 && m_run == 15) && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        check("reach_debounce_15", 32'(budget < 2000), 32'(1));
        #1;
        n_reset = 1'b0;
        release_all();
        repeat (5) @(negedge clk);
        #1;
        check("midreset_col", 32'(col_o), 32'(4'b1110));
        check("midreset_valid", 32'(key_valid), 32'(0));
        check("midreset_code", 32'(key_code), 32'(0));
        n_reset = 1'b1;
        wait_ticks(3);
        check("midreset_no_event", 32'(ev_count - ev0), 32'(0));
        pressed[1][1] = 1'b1;
        wait_ticks(30);
        check("after_reset_events", 32'(ev_count - ev0), 32'(1));
        check("after_reset_code", 32'(ev_code), 32'(5));
        release_all();
        wait_ticks(25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
